// File: rtl/zxuno_regport_pkg.sv
// zxuno_regs_pkg: shared constants for the ZX-UNO register bank.
// Contents: the I/O port numbers, the register index map and the 2-bit
// state encoding used by the register-port front end.
package zxuno_regs_pkg;

    localparam logic [15:0] ZXUNO_ADDR_PORT = 16'hFC3B;
    localparam logic [15:0] ZXUNO_DATA_PORT = 16'hFD3B;

    localparam logic [7:0] MASTERCONF = 8'h00;
    localparam logic [7:0] MASTERMAPPER = 8'h01;
    localparam logic [7:0] SCANCODE = 8'h04;
    localparam logic [7:0] KEYBSTAT = 8'h05;
    localparam logic [7:0] COREID = 8'hFF;

    typedef enum logic [1:0] {IDLE, AWR, DWR, HOLD} regport_state_t;

endpackage

// File: rtl/zxuno_regport_if.sv
// zxuno_regport_if: CPU-side bus and register strobes of the register port.
// master: CPU side (drives cpu_a, cpu_din, iorq_n, m1_n, rd_n, wr_n).
// slave:  register port (drives zxuno_addr, zxuno_regrd, zxuno_regwr,
//         regaddr_changed, dout, oe_n).
interface zxuno_regport_if;

    logic [15:0] cpu_a;
    logic [7:0]  cpu_din;
    logic        iorq_n;
    logic        m1_n;
    logic        rd_n;
    logic        wr_n;
    logic [7:0]  zxuno_addr;
    logic        zxuno_regrd;
    logic        zxuno_regwr;
    logic        regaddr_changed;
    logic [7:0]  dout;
    logic        oe_n;

    modport master (
        output cpu_a, cpu_din, iorq_n, m1_n, rd_n, wr_n,
        input  zxuno_addr, zxuno_regrd, zxuno_regwr, regaddr_changed, dout, oe_n
    );

    modport slave (
        input  cpu_a, cpu_din, iorq_n, m1_n, rd_n, wr_n,
        output zxuno_addr, zxuno_regrd, zxuno_regwr, regaddr_changed, dout, oe_n
    );

endinterface

// File: rtl/zxuno_regport_io_strobe_edge.sv
// io_strobe_edge: start/end detector for a CPU I/O strobe.
// Ports: clk, rst_n (sync, active-low), strobe (active-high level),
//        start (first cycle of strobe), stop (first cycle after strobe).
// The previous-strobe flag resets to 1 so a strobe already active when
// reset releases is not reported as a new start.
module io_strobe_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    output logic start,
    output logic stop
);

    logic q;

    always_ff @(posedge clk)
        q <= !rst_n ? 1'b1 : strobe;

    assign start = strobe & !q;
    assign stop = !strobe & q;

endmodule

// File: rtl/zxuno_regport.sv
// zxuno_regport: ZX-UNO register index/data port decoder.
// Ports: clk, rst_n (sync, active-low), bus (zxuno_regport_if.slave).
// Produces zxuno_addr, zxuno_regrd (level), zxuno_regwr and
// regaddr_changed (one-clock pulses), dout/oe_n readback.
// Macro ZXUNO_ADDR_READBACK_EN makes the address port readable.
import zxuno_regs_pkg::*;

module zxuno_regport #(
    parameter logic [15:0] ADDR_PORT = ZXUNO_ADDR_PORT,
    parameter logic [15:0] DATA_PORT = ZXUNO_DATA_PORT,
    parameter logic [7:0]  RESET_ADDR = 8'h00
) (
    input logic clk,
    input logic rst_n,
    zxuno_regport_if.slave bus
);

    logic io_ok, hit_a, hit_d, wr_act, rd_act, wr_start, wr_end_unused;
    logic [7:0] addr_q;
    regport_state_t state, state_nx;

    assign io_ok = !bus.iorq_n & bus.m1_n;
    assign hit_a = io_ok & (bus.cpu_a == ADDR_PORT);
    assign hit_d = io_ok & (bus.cpu_a == DATA_PORT);
    assign wr_act = !bus.wr_n;
    assign rd_act = !bus.rd_n & bus.wr_n;

    io_strobe_edge u_wr_edge (
        .clk(clk),
        .rst_n(rst_n),
        .strobe(wr_act & (hit_a | hit_d)),
        .start(wr_start),
        .stop(wr_end_unused)
    );

    // Index is captured on the start edge so it is already valid while
    // regaddr_changed is high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= HOLD;
            addr_q <= RESET_ADDR;
        end else begin
            state <= state_nx;
            if (state == IDLE && wr_start && hit_a)
                addr_q <= bus.cpu_din;
        end
    end

    // HOLD swallows the rest of a long or waited write until the cycle ends.
    always_comb begin
        state_nx = state;
        state_nx = state == IDLE ? (wr_start ? (hit_a ? AWR : DWR) : IDLE) :
                   state == HOLD ? ((bus.iorq_n | bus.wr_n) ? IDLE : HOLD) : HOLD;
    end

    assign bus.zxuno_addr = addr_q;
    assign bus.regaddr_changed = state == AWR;
    assign bus.zxuno_regwr = state == DWR;
    assign bus.zxuno_regrd = hit_d & rd_act;

`ifdef ZXUNO_ADDR_READBACK_EN
    logic [7:0] dout_q;

    always_ff @(posedge clk)
        dout_q <= !rst_n ? 8'h00 : addr_q;

    assign bus.dout = dout_q;
    assign bus.oe_n = !(hit_a & rd_act);
`else
    assign bus.dout = 8'h00;
    assign bus.oe_n = 1'b1;
`endif

endmodule

// File: tb/tb_zxuno_regport.sv
// tb_zxuno_regport: self-checking bench for zxuno_regport.
// Drives whole Z80 I/O cycles and predicts outputs per cycle from the
// cycle-level description: pulses one clock after a write begins, regrd
// and oe_n as pure decode of the live bus, dout one clock behind the index.
module tb_zxuno_regport;

    localparam logic [15:0] A_PORT = 16'hFC3B;
    localparam logic [15:0] D_PORT = 16'hFD3B;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int cmp = 0;
    int errs = 0;
    logic [7:0] exp_addr = 8'h00;
    logic [7:0] dout_q = 8'h00;

    zxuno_regport_if bus ();

    zxuno_regport dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        cmp++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.cpu_a = 16'h0000;
        bus.cpu_din = 8'h00;
        bus.iorq_n = 1'b1;
        bus.m1_n = 1'b1;
        bus.rd_n = 1'b1;
        bus.wr_n = 1'b1;
    endtask

    // One clock: sample at the falling edge, then advance past the rising edge.
    task automatic step(input bit e_chg, input bit e_wr);
        logic io_ok, rd, e_rd, e_oe;
        logic [7:0] e_dout;
        @(negedge clk);
        io_ok = !bus.iorq_n && bus.m1_n;
        rd = !bus.rd_n && bus.wr_n;
        e_rd = io_ok && bus.cpu_a == D_PORT && rd;
`ifdef ZXUNO_ADDR_READBACK_EN
        e_oe = !(io_ok && bus.cpu_a == A_PORT && rd);
        e_dout = dout_q;
`else
        e_oe = 1'b1;
        e_dout = 8'h00;
`endif
        chk("regaddr_changed", 16'(bus.regaddr_changed), 16'(e_chg));
        chk("zxuno_regwr", 16'(bus.zxuno_regwr), 16'(e_wr));
        chk("zxuno_regrd", 16'(bus.zxuno_regrd), 16'(e_rd));
        chk("zxuno_addr", 16'(bus.zxuno_addr), 16'(exp_addr));
        chk("oe_n", 16'(bus.oe_n), 16'(e_oe));
        chk("dout", 16'(bus.dout), 16'(e_dout));
        dout_q = rst_n ? exp_addr : 8'h00;
        if (!rst_n)
            exp_addr = 8'h00;
        @(posedge clk);
        #1;
    endtask

    // A full I/O cycle of len clocks followed by two idle clocks.
    task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d, input bit wr,
                             input bit both, input bit inta, input int len);
        bit hit_a, hit_d;
        hit_a = !inta && a == A_PORT;
        hit_d = !inta && a == D_PORT;
        for (int i = 0; i < len + 2; i++) begin
            if (i < len) begin
                bus.cpu_a = a;
                bus.cpu_din = d;
                bus.iorq_n = 1'b0;
                bus.m1_n = !inta;
                bus.wr_n = !wr;
                bus.rd_n = wr && !both;
            end else
                idle();
            if (i == 1 && wr && hit_a)
                exp_addr = d;
            step(i == 1 && wr && hit_a, i == 1 && wr && hit_d);
        end
    endtask

    initial begin
        logic [15:0] a;
        int unsigned sel;
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        step(0, 0);
        step(0, 0);
        rst_n = 1'b1;
        step(0, 0);
        step(0, 0);
        bus_cycle(A_PORT, 8'hFF, 1, 0, 0, 3);
        bus_cycle(D_PORT, 8'h5A, 1, 0, 0, 5);
        bus_cycle(D_PORT, 8'h00, 0, 0, 0, 3);
        bus_cycle(16'hFD3C, 8'h00, 0, 0, 0, 3);
        bus_cycle(A_PORT, 8'h12, 1, 0, 1, 3);
        bus_cycle(D_PORT, 8'h00, 1, 1, 0, 2);
        bus_cycle(A_PORT, 8'h01, 1, 0, 0, 1);
        // Reset asserted in the clock a write starts, released with WR still low.
        bus.cpu_a = A_PORT;
        bus.cpu_din = 8'h77;
        bus.iorq_n = 1'b0;
        bus.wr_n = 1'b0;
        rst_n = 1'b0;
        step(0, 0);
        step(0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++)
            step(0, 0);
        idle();
        step(0, 0);
        step(0, 0);
        bus_cycle(A_PORT, 8'h3C, 1, 0, 0, 2);
        bus_cycle(A_PORT, 8'h00, 0, 0, 0, 3);
        bus_cycle(A_PORT, 8'h3C, 1, 0, 0, 2);
        for (int n = 0; n < 80; n++) begin
            sel = $urandom_range(0, 4);
            a = sel == 0 ? A_PORT : sel == 1 ? D_PORT : sel == 2 ? 16'hFC3C :
                sel == 3 ? 16'hFD3A : 16'($urandom);
            bus_cycle(a, 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                      $urandom_range(0, 4) == 0, int'($urandom_range(1, 5)));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end

endmodule
